bmem_responder: RTL and testbench
=================================

// Module: bmem_responder
// PURPOSE
// - Synthesizable burst-memory responder: the slave end of the bmem interface driven by the cpu/cache.
// - Accepts single-cycle line read requests and 4-beat line write bursts.
// - Stores lines in an on-chip 64-bit-wide array.
// - Returns each read as 4 consecutive 64-bit beats tagged with the request address, after a fixed minimum latency.
// - Used as the DRAM stand-in for FPGA/emulation builds and as the golden responder in cpu-level benches.
// PARAMETERS
// - LINE_IDX_BITS  10  log2 of the number of 256-bit lines stored (1024 lines = 32 KiB).
// - LATENCY        8   minimum cycles from read acceptance to first rvalid beat; must be >= 2.
// - RQ_DEPTH       4   outstanding read-request queue depth; must be a power of 2.
// PORTS
// - clk          in   1   clock
// - rst          in   1   synchronous, active-high reset
// - bmem_addr    in   32  request byte address; bits [4:0] ignored (line aligned)
// - bmem_read    in   1   read request, one cycle, valid when bmem_ready=1
// - bmem_write   in   1   write burst; held high 4 consecutive cycles with addr constant
// - bmem_wdata   in   64  write beat data, beat k on cycle k of the burst
// - bmem_ready   out  1   responder can accept a new request this cycle
// - bmem_raddr   out  32  line address of the burst on rdata ({line,5'b0})
// - bmem_rdata   out  64  read beat data
// - bmem_rvalid  out  1   rdata/raddr valid this cycle
// - proto_err    out  1   sticky: master violated protocol since reset
// BEHAVIOUR
// - Reset: bmem_ready=0 during rst and 1 the first cycle after; rvalid=0; raddr/rdata=0; proto_err=0.
//   Read queue is emptied; write collector returns to W_IDLE. Array contents are not cleared.
//   rst mid-burst: the burst is aborted and rvalid=0 from the next cycle; partial write beats already stored remain.
// - Line index = bmem_addr[LINE_IDX_BITS+4:5]; higher address bits are ignored, so out-of-range addresses alias.
// - bmem_ready = !rst && (rq_count < RQ_DEPTH) && (wstate == W_IDLE).
// - Read accept: bmem_read && bmem_ready && !bmem_write.
//   Push {addr[31:5], stamp=cycle_ctr} into the read queue.
//   cycle_ctr is a free-running 16-bit counter; compare with modulo subtraction.
// - Write collector FSM:
//   - W_IDLE -> W_BEAT on bmem_write && bmem_ready; beat 0 is written to array[line][0] that cycle; latch line.
//   - W_BEAT: beats 1..3 are written on the following cycles regardless of ready. Return to W_IDLE after beat 3.
//   - bmem_write low during W_BEAT: set proto_err, abandon the burst, return to W_IDLE.
//   - Each beat commits to the array in its own cycle; a read accepted after the burst ends sees the new data.
// - bmem_read && bmem_write in the same cycle: the write wins, the read is dropped, proto_err is set.
//   A request while bmem_ready=0 (other than write beats 1..3) is ignored and sets proto_err.
// - Response FSM:
//   - R_IDLE -> R_BURST when the queue is non-empty and (cycle_ctr - head.stamp) >= LATENCY-1. Beat 0 is output on the next cycle.
//   - R_BURST: beats 0,1,2,3 on 4 consecutive cycles with rvalid=1 and raddr={line,5'b0} constant.
//     Pop the head on beat 3. If the next head is already eligible, its beat 0 follows with no bubble; otherwise go to R_IDLE.
//   - The array read is registered; the address of beat k+1 is presented during beat k.
// - Reads are returned strictly in acceptance order.
// - Write/read array-port conflict in the same cycle: the write commits first. A read beat fetched that cycle for the same line sees old data; ordering is the master's responsibility.
// - Queue full: ready=0 until the pop on beat 3. A read arriving on the pop cycle is accepted only next cycle, because ready is computed from the registered count.
// STRUCTURE
// - rv32i_types gets:
//   - bmem_rq_t struct {logic [26:0] line_addr; logic [15:0] stamp;}
//   - enums bmem_wstate_t {W_IDLE,W_BEAT} and bmem_rstate_t {R_IDLE,R_BURST}
//   - localparam BMEM_BEATS=4
// - One sub-module: bmem_rq_fifo (parameterized depth, bmem_rq_t payload, push/pop/full/empty/count, first-word-fall-through).
// - The array is an inferred single-clock memory with 1 write port and 1 registered read port, (2**LINE_IDX_BITS)*4 x 64.
// TESTING
// - Write line 0x100 beats {A0,A1,A2,A3}, then read 0x100 at cycle T -> rvalid on T+8..T+11, rdata A0..A3, raddr=0x100.
// - 4 back-to-back reads -> ready=0 after the 4th; 16 contiguous rvalid beats in order; ready returns the cycle after the first pop.
// - Read and write asserted together at addr 0x40 -> write committed, no rvalid, proto_err=1 and stays 1.
// - Assert rst during beat 1 of a burst -> rvalid=0 next cycle; ready=1 one cycle after rst drops; earlier written data still readable.
// - Write 0x1eceb000 with LINE_IDX_BITS=10, read 0x0000b000 (alias) -> same data returned, raddr=0x0000b000.
// - Write drops after 2 beats -> proto_err=1; W_IDLE; beats 0-1 updated, beats 2-3 keep old values.

Source files
------------

// File: rtl/bmem_responder_pkg.sv
// Shared types and helpers for the bmem burst-memory responder.
package bmem_responder_pkg;

  localparam int BMEM_BEATS = 4;

  typedef struct packed {
    logic [26:0] line_addr;
    logic [15:0] stamp;
  } bmem_rq_t;

  typedef enum logic { W_IDLE, W_BEAT } bmem_wstate_t;
  typedef enum logic { R_IDLE, R_BURST } bmem_rstate_t;

  // Age test on the free-running stamp counter; modulo subtraction keeps it wrap-safe.
  function automatic logic stamp_aged(input logic [15:0] now,
                                      input logic [15:0] stamp,
                                      input logic [15:0] min_age);
    logic [15:0] age;
    age = now - stamp;
    return age >= min_age;
  endfunction

endpackage

// File: rtl/bmem_rq_fifo.sv
// First-word-fall-through queue of outstanding read requests.
// Also exposes the entry behind the head so back-to-back bursts can chain.
module bmem_rq_fifo
  import bmem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  bmem_rq_t                push_data_i,
  input  logic                    pop_i,
  output bmem_rq_t                head_o,
  output bmem_rq_t                next_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  bmem_rq_t      slots_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_inc;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign rd_ptr_inc = rd_ptr_q + PW'(1);
  assign head_o     = slots_q[rd_ptr_q];
  assign next_o     = slots_q[rd_ptr_inc];

  always_ff @(posedge clk) begin
    if (push_ok) slots_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_inc;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bmem_responder.sv
// Burst-memory responder: collects 4-beat line writes into an on-chip array and
// returns queued line reads as 4-beat bursts after a minimum latency, in order.
module bmem_responder
  import bmem_responder_pkg::*;
#(
  parameter int LINE_IDX_BITS = 10,
  parameter int LATENCY       = 8,
  parameter int RQ_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid,
  output logic        proto_err
);

  localparam int              BW        = $clog2(BMEM_BEATS);
  localparam int              AW        = LINE_IDX_BITS + BW;
  localparam int              CW        = $clog2(RQ_DEPTH) + 1;
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BMEM_BEATS - 1);
  localparam logic [15:0]     MIN_AGE   = 16'(LATENCY - 1);

  logic [63:0]              line_mem [2**AW];
  logic [63:0]              mem_rdata_q;
  logic                     mem_we;
  logic                     mem_re;
  logic [AW-1:0]            mem_waddr;
  logic [AW-1:0]            mem_raddr;

  bmem_wstate_t             wstate_q, wstate_d;
  logic [BW-1:0]            wbeat_q, wbeat_d;
  logic [LINE_IDX_BITS-1:0] wline_q, wline_d;
  bmem_rstate_t             rstate_q, rstate_d;
  logic [BW-1:0]            rbeat_q, rbeat_d;
  logic [BW-1:0]            rbeat_inc;
  logic [15:0]              cycle_q;
  logic                     proto_err_q, proto_err_d;

  logic [LINE_IDX_BITS-1:0] req_line;
  bmem_rq_t                 rq_push_data;
  bmem_rq_t                 rq_head;
  bmem_rq_t                 rq_next;
  logic                     rq_push, rq_pop, rq_full, rq_empty;
  logic [CW-1:0]            rq_count;
  logic                     head_ready, next_ready;
  logic                     unused_bits;

  assign req_line     = bmem_addr[LINE_IDX_BITS+4:5];
  assign bmem_ready   = !rst && !rq_full && (wstate_q == W_IDLE);
  assign rq_push      = bmem_read && bmem_ready && !bmem_write;
  assign rq_push_data = '{line_addr: bmem_addr[31:5], stamp: cycle_q};
  assign head_ready   = !rq_empty && stamp_aged(cycle_q, rq_head.stamp, MIN_AGE);
  assign next_ready   = (rq_count > CW'(1)) && stamp_aged(cycle_q, rq_next.stamp, MIN_AGE);
  assign rbeat_inc    = rbeat_q + BW'(1);
  assign unused_bits  = ^{bmem_addr[4:0], rq_next.line_addr};

  bmem_rq_fifo #(
    .DEPTH(RQ_DEPTH)
  ) u_rq_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (rq_push),
    .push_data_i(rq_push_data),
    .pop_i      (rq_pop),
    .head_o     (rq_head),
    .next_o     (rq_next),
    .full_o     (rq_full),
    .empty_o    (rq_empty),
    .count_o    (rq_count)
  );

  // Write collector and protocol checking.
  always_comb begin
    wstate_d    = wstate_q;
    wbeat_d     = wbeat_q;
    wline_d     = wline_q;
    mem_we      = 1'b0;
    mem_waddr   = {wline_q, wbeat_q};
    proto_err_d = proto_err_q;
    if (bmem_read && (bmem_write || !bmem_ready)) proto_err_d = 1'b1;
    case (wstate_q)
      W_IDLE: begin
        if (bmem_write && bmem_ready) begin
          mem_we    = 1'b1;
          mem_waddr = {req_line, BW'(0)};
          wline_d   = req_line;
          wbeat_d   = BW'(1);
          wstate_d  = W_BEAT;
        end else if (bmem_write) begin
          proto_err_d = 1'b1;
        end
      end
      W_BEAT: begin
        if (bmem_write) begin
          mem_we = 1'b1;
          if (wbeat_q == LAST_BEAT) wstate_d = W_IDLE;
          else                      wbeat_d  = wbeat_q + BW'(1);
        end else begin
          proto_err_d = 1'b1;
          wstate_d    = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Response sequencer: the array address for beat k+1 is issued during beat k.
  always_comb begin
    rstate_d  = rstate_q;
    rbeat_d   = rbeat_q;
    rq_pop    = 1'b0;
    mem_re    = 1'b0;
    mem_raddr = {rq_head.line_addr[LINE_IDX_BITS-1:0], rbeat_inc};
    case (rstate_q)
      R_IDLE: begin
        if (head_ready) begin
          rstate_d  = R_BURST;
          rbeat_d   = '0;
          mem_re    = 1'b1;
          mem_raddr = {rq_head.line_addr[LINE_IDX_BITS-1:0], BW'(0)};
        end
      end
      R_BURST: begin
        if (rbeat_q != LAST_BEAT) begin
          rbeat_d = rbeat_inc;
          mem_re  = 1'b1;
        end else begin
          rq_pop = 1'b1;
          if (next_ready) begin
            rbeat_d   = '0;
            mem_re    = 1'b1;
            mem_raddr = {rq_next.line_addr[LINE_IDX_BITS-1:0], BW'(0)};
          end else begin
            rstate_d = R_IDLE;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q    <= W_IDLE;
      wbeat_q     <= '0;
      wline_q     <= '0;
      rstate_q    <= R_IDLE;
      rbeat_q     <= '0;
      cycle_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      wbeat_q     <= wbeat_d;
      wline_q     <= wline_d;
      rstate_q    <= rstate_d;
      rbeat_q     <= rbeat_d;
      cycle_q     <= cycle_q + 16'd1;
      proto_err_q <= proto_err_d;
    end
  end

  // Read-before-write on a same-address collision; a beat cut off by rst is not stored.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) line_mem[mem_waddr] <= bmem_wdata;
    if (mem_re)         mem_rdata_q         <= line_mem[mem_raddr];
  end

  assign bmem_rvalid = (rstate_q == R_BURST);
  assign bmem_raddr  = bmem_rvalid ? {rq_head.line_addr, 5'b0} : '0;
  assign bmem_rdata  = bmem_rvalid ? mem_rdata_q : '0;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_bmem_responder.sv
// Scoreboard bench for bmem_responder: directed scenarios then randomized traffic
// against a line-level reference model with spec-derived burst timing.
module tb_bmem_responder;

  localparam int LIB   = 10;
  localparam int LAT   = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bmem_addr = '0;
  logic        bmem_read = 1'b0;
  logic        bmem_write = 1'b0;
  logic [63:0] bmem_wdata = '0;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
  logic        proto_err;

  bmem_responder #(
    .LINE_IDX_BITS(LIB),
    .LATENCY      (LAT),
    .RQ_DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    int          at;
    int          beat;
  } beat_t;

  beat_t       sb[$];
  logic [63:0] model_mem [int];
  bit          written [int];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  int          wbeat = 0;
  int          wline = 0;
  int          prev_start = -100;
  bit          exp_err = 1'b0;
  bit          pend_viol = 1'b0;
  bit          pend_rst = 1'b0;
  int          pool [8] = '{8, 2, 'h180, 'h3ff, 0, 'h55, 'h2aa, 'h111};

  function automatic int line_of(input logic [31:0] a);
    return int'(a[LIB+4:5]);
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int bursts_pending();
    int n = 0;
    foreach (sb[i]) if (sb[i].beat == 3) n++;
    return n;
  endfunction

  function automatic bit line_pending(input int ln);
    foreach (sb[i]) if (line_of(sb[i].addr) == ln) return 1'b1;
    return 1'b0;
  endfunction

  // A read accepted at cycle t starts no earlier than t+LAT; it chains with no bubble
  // only if already eligible on the previous burst's last beat, else it waits for R_IDLE.
  function automatic void schedule(input logic [31:0] a, input int t);
    int start;
    int ln;
    ln = line_of(a);
    if (t + LAT <= prev_start + 4) start = prev_start + 4;
    else start = (t + LAT > prev_start + 5) ? t + LAT : prev_start + 5;
    prev_start = start;
    for (int k = 0; k < 4; k++)
      sb.push_back('{addr: {a[31:5], 5'b0}, data: model_mem[ln*4+k], at: start + k, beat: k});
  endfunction

  // One clock cycle of stimulus; with gate set, requests are only raised when the model says ready.
  task automatic step(input bit r, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [63:0] wd, input bit gate, output bit issued);
    bit exp_ready;
    bit viol;
    int cur;
    int ln;
    @(posedge clk);
    #1;
    cur = cyc;
    if (pend_rst) exp_err = 1'b0;
    else if (pend_viol) exp_err = 1'b1;
    exp_ready = !r && (bursts_pending() < DEPTH) && (wbeat == 0);
    if (gate && !exp_ready) begin
      rd = 1'b0;
      wr = 1'b0;
    end
    issued     = rd || wr;
    rst        = r;
    bmem_read  = rd;
    bmem_write = wr;
    bmem_addr  = a;
    bmem_wdata = wd;
    #1;
    check("ready", 64'(bmem_ready), 64'(exp_ready));
    viol = 1'b0;
    ln   = line_of(a);
    if (r) begin
      while (sb.size() > 0 && sb[sb.size()-1].at > cur) void'(sb.pop_back());
      wbeat      = 0;
      prev_start = -100;
    end else if (wbeat != 0) begin
      if (wr) begin
        model_mem[wline*4+wbeat] = wd;
        if (wbeat == 3) begin
          written[wline] = 1'b1;
          wbeat = 0;
        end else begin
          wbeat++;
        end
      end else begin
        viol  = 1'b1;
        wbeat = 0;
      end
      if (rd) viol = 1'b1;
    end else if (wr) begin
      if (exp_ready) begin
        model_mem[ln*4] = wd;
        wline = ln;
        wbeat = 1;
      end
      if (rd || !exp_ready) viol = 1'b1;
    end else if (rd) begin
      if (exp_ready) schedule(a, cur);
      else viol = 1'b1;
    end
    pend_rst  = r;
    pend_viol = viol;
  endtask

  task automatic idle(input int n);
    bit iss;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, iss);
  endtask

  task automatic do_reset();
    bit iss;
    step(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, iss);
    step(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, iss);
  endtask

  task automatic do_read(input logic [31:0] a);
    bit iss;
    step(1'b0, 1'b1, 1'b0, a, 64'h0, 1'b0, iss);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] base, input int beats);
    bit iss;
    for (int k = 0; k < beats; k++) step(1'b0, 1'b0, 1'b1, a, base + 64'(k), 1'b0, iss);
  endtask

  // Response monitor: every cycle, rvalid must match whether a scheduled beat is due.
  always @(negedge clk) begin : p_mon
    bit    due;
    beat_t e;
    if (mon_en) begin
      due = (sb.size() > 0) && (sb[0].at == cyc);
      check("rvalid", 64'(bmem_rvalid), 64'(due));
      check("proto_err", 64'(proto_err), 64'(exp_err));
      if (due) begin
        e = sb.pop_front();
        if (bmem_rvalid) begin
          check("raddr", 64'(bmem_raddr), 64'(e.addr));
          check("rdata", bmem_rdata, e.data);
        end
        if (e.beat == 3)
          $display("read burst raddr=%h last beat at cycle %0d", e.addr, cyc);
      end
    end
  end

  initial begin : p_stim
    bit          iss;
    logic [31:0] a;
    logic [31:0] r32;
    int          op;
    int          idx;
    int          t;

    do_reset();
    mon_en = 1'b1;
    idle(1);

    // Write then read a line; first beat expected exactly LAT cycles after acceptance.
    do_write(32'h0000_0100, 64'hA0A0_0000_0000_0000, 4);
    idle(1);
    do_read(32'h0000_0100);
    idle(12);

    // Four back-to-back reads fill the queue; ready drops, 16 contiguous beats follow.
    do_read(32'h0000_0100);
    do_read(32'h0000_0100);
    do_read(32'h0000_0100);
    do_read(32'h0000_0100);
    idle(26);

    // Read and write together: write wins, read dropped, proto_err sticks.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0040, 64'hB0B0_0000_0000_0000, 1'b0, iss);
    do_write(32'h0000_0040, 64'hB0B0_0000_0000_0001, 3);
    idle(2);
    do_read(32'h0000_0040);
    idle(12);

    // Reset on beat 1 of a response burst; earlier data must survive.
    do_read(32'h0000_0040);
    idle(8);
    step(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, iss);
    idle(1);
    do_read(32'h0000_0100);
    idle(12);

    // Aliasing address bits above the line index.
    do_write(32'h1ECE_B000, 64'hC0C0_0000_0000_0000, 4);
    idle(1);
    do_read(32'h0000_B000);
    idle(12);

    // Burst abandoned after two beats: beats 2-3 keep the old contents.
    do_write(32'h0000_0100, 64'hD0D0_0000_0000_0000, 2);
    idle(1);
    do_read(32'h0000_0100);
    idle(12);

    // Randomized traffic over a small pool of lines with random alias bits.
    do_reset();
    idle(1);
    for (int i = 0; i < 400; i++) begin
      op  = $urandom_range(0, 9);
      idx = pool[$urandom_range(0, 7)];
      r32 = $urandom();
      a   = r32;
      a[LIB+4:5] = idx[LIB-1:0];
      if (op < 4) begin
        idle(1);
      end else if (op < 8) begin
        if (written.exists(idx)) step(1'b0, 1'b1, 1'b0, a, 64'h0, 1'b1, iss);
        else idle(1);
      end else if (!line_pending(idx)) begin
        step(1'b0, 1'b0, 1'b1, a, {$urandom(), $urandom()}, 1'b1, iss);
        if (iss) begin
          for (t = 1; t < 4; t++)
            step(1'b0, 1'b0, 1'b1, a, {$urandom(), $urandom()}, 1'b0, iss);
        end
      end else begin
        idle(1);
      end
    end
    idle(40);
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
